// File: rtl/result_reader.sv
// Reads rows of a result bank (a/b/c) and streams each row to the host as
// BUS_WIDTH beats, LSB slice first, with valid/ready handshaking.
module result_reader #(
  parameter int ARRAY_SIZE        = 32,
  parameter int OUTPUT_DATA_WIDTH = 32,
  parameter int BUS_WIDTH         = 64
) (
  input  logic                                    clk,
  input  logic                                    srstn,
  input  logic                                    rd_start,
  input  logic [1:0]                              rd_bank,
  input  logic [6:0]                              rd_rows,
  output logic                                    sram_read_enable_a0,
  output logic                                    sram_read_enable_b0,
  output logic                                    sram_read_enable_c0,
  output logic [5:0]                              sram_raddr_a,
  output logic [5:0]                              sram_raddr_b,
  output logic [5:0]                              sram_raddr_c,
  input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] sram_rdata_a,
  input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] sram_rdata_b,
  input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] sram_rdata_c,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [BUS_WIDTH-1:0]                    out_data,
  output logic                                    out_row_last,
  output logic                                    out_last,
  output logic                                    busy,
  output logic                                    rd_done,
  output logic                                    rd_err
);

  localparam int ROW_W  = ARRAY_SIZE * OUTPUT_DATA_WIDTH;
  localparam int BEATS  = ROW_W / BUS_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_WAIT = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [1:0]        bank_r, bank_nxt_s;
  logic [6:0]        rows_r, rows_nxt_s;
  logic [5:0]        row_r, row_nxt_s;
  logic [BEAT_W-1:0] beat_r, beat_nxt_s;
  logic              err_nxt_s;
  logic              last_row_s;
  logic [ROW_W-1:0]  rdata_sel_s, buf_nxt_s, row_buf_r;

  logic              ren_a_nxt_s, ren_b_nxt_s, ren_c_nxt_s;
  logic [5:0]        raddr_a_nxt_s, raddr_b_nxt_s, raddr_c_nxt_s;
  logic              valid_nxt_s, row_last_nxt_s, last_nxt_s;
  logic [BUS_WIDTH-1:0] data_nxt_s;

  assign last_row_s = ({1'b0, row_r} == (rows_r - 7'd1));

  // State and transfer counters
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state_r <= S_IDLE;
      bank_r  <= 2'd0;
      rows_r  <= 7'd0;
      row_r   <= 6'd0;
      beat_r  <= {BEAT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      bank_r  <= bank_nxt_s;
      rows_r  <= rows_nxt_s;
      row_r   <= row_nxt_s;
      beat_r  <= beat_nxt_s;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_nxt_s = state_r;
    bank_nxt_s  = bank_r;
    rows_nxt_s  = rows_r;
    row_nxt_s   = row_r;
    beat_nxt_s  = beat_r;
    err_nxt_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (rd_start) begin
          if (rd_bank == 2'd3) begin
            err_nxt_s = 1'b1;
          end else if (rd_rows == 7'd0) begin
            state_nxt_s = S_DONE;
          end else begin
            bank_nxt_s  = rd_bank;
            rows_nxt_s  = (rd_rows > 7'd64) ? 7'd64 : rd_rows;
            row_nxt_s   = 6'd0;
            beat_nxt_s  = {BEAT_W{1'b0}};
            state_nxt_s = S_READ;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_READ: state_nxt_s = S_WAIT;
      S_WAIT: begin
        beat_nxt_s  = {BEAT_W{1'b0}};
        state_nxt_s = S_SEND;
      end
      S_SEND: begin
        if (out_ready) begin
          if (beat_r == BEAT_LAST) begin
            beat_nxt_s = {BEAT_W{1'b0}};
            if (last_row_s) begin
              state_nxt_s = S_DONE;
            end else begin
              row_nxt_s   = row_r + 6'd1;
              state_nxt_s = S_READ;
            end
          end else begin
            beat_nxt_s = beat_r + {{(BEAT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_nxt_s = S_SEND;
        end
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Selected bank read data
  always_comb begin
    case (bank_r)
      2'd0:    rdata_sel_s = sram_rdata_a;
      2'd1:    rdata_sel_s = sram_rdata_b;
      2'd2:    rdata_sel_s = sram_rdata_c;
      default: rdata_sel_s = {ROW_W{1'b0}};
    endcase
  end

  // Row buffer, loaded while the SRAM data is valid
  always_ff @(posedge clk) begin
    if (state_r == S_WAIT) begin
      row_buf_r <= rdata_sel_s;
    end
  end

  // Outputs are computed from the upcoming state so they can be registered
  // without adding a cycle of latency.
  always_comb begin
    buf_nxt_s      = (state_r == S_WAIT) ? rdata_sel_s : row_buf_r;
    ren_a_nxt_s    = (state_nxt_s == S_READ) && (bank_nxt_s == 2'd0);
    ren_b_nxt_s    = (state_nxt_s == S_READ) && (bank_nxt_s == 2'd1);
    ren_c_nxt_s    = (state_nxt_s == S_READ) && (bank_nxt_s == 2'd2);
    raddr_a_nxt_s  = ren_a_nxt_s ? row_nxt_s : 6'd0;
    raddr_b_nxt_s  = ren_b_nxt_s ? row_nxt_s : 6'd0;
    raddr_c_nxt_s  = ren_c_nxt_s ? row_nxt_s : 6'd0;
    valid_nxt_s    = (state_nxt_s == S_SEND);
    if (valid_nxt_s) begin
      data_nxt_s = buf_nxt_s[int'(beat_nxt_s)*BUS_WIDTH +: BUS_WIDTH];
    end else begin
      data_nxt_s = {BUS_WIDTH{1'b0}};
    end
    row_last_nxt_s = valid_nxt_s && (beat_nxt_s == BEAT_LAST);
    last_nxt_s     = row_last_nxt_s && ({1'b0, row_nxt_s} == (rows_nxt_s - 7'd1));
  end

  // Output registers
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      sram_read_enable_a0 <= 1'b0;
      sram_read_enable_b0 <= 1'b0;
      sram_read_enable_c0 <= 1'b0;
      sram_raddr_a        <= 6'd0;
      sram_raddr_b        <= 6'd0;
      sram_raddr_c        <= 6'd0;
      out_valid           <= 1'b0;
      out_data            <= {BUS_WIDTH{1'b0}};
      out_row_last        <= 1'b0;
      out_last            <= 1'b0;
      busy                <= 1'b0;
      rd_done             <= 1'b0;
      rd_err              <= 1'b0;
    end else begin
      sram_read_enable_a0 <= ren_a_nxt_s;
      sram_read_enable_b0 <= ren_b_nxt_s;
      sram_read_enable_c0 <= ren_c_nxt_s;
      sram_raddr_a        <= raddr_a_nxt_s;
      sram_raddr_b        <= raddr_b_nxt_s;
      sram_raddr_c        <= raddr_c_nxt_s;
      out_valid           <= valid_nxt_s;
      out_data            <= data_nxt_s;
      out_row_last        <= row_last_nxt_s;
      out_last            <= last_nxt_s;
      busy                <= (state_nxt_s != S_IDLE);
      rd_done             <= (state_nxt_s == S_DONE);
      rd_err              <= err_nxt_s;
    end
  end

endmodule

// File: tb/tb_result_reader.sv
// Self-checking bench for result_reader: table-driven and random transfers
// checked against a queue-based model, plus timing and reset sequences.
module tb_result_reader;

  logic          clk, srstn, rd_start;
  logic [1:0]    rd_bank;
  logic [6:0]    rd_rows;
  logic          ren_a, ren_b, ren_c;
  logic [5:0]    raddr_a, raddr_b, raddr_c;
  logic [1023:0] rdata_a, rdata_b, rdata_c;
  logic          out_valid, out_ready, out_row_last, out_last;
  logic [63:0]   out_data;
  logic          busy, rd_done, rd_err;

  result_reader dut (
    .clk(clk), .srstn(srstn), .rd_start(rd_start), .rd_bank(rd_bank), .rd_rows(rd_rows),
    .sram_read_enable_a0(ren_a), .sram_read_enable_b0(ren_b), .sram_read_enable_c0(ren_c),
    .sram_raddr_a(raddr_a), .sram_raddr_b(raddr_b), .sram_raddr_c(raddr_c),
    .sram_rdata_a(rdata_a), .sram_rdata_b(rdata_b), .sram_rdata_c(rdata_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row_last(out_row_last), .out_last(out_last),
    .busy(busy), .rd_done(rd_done), .rd_err(rd_err)
  );

  typedef struct { logic [63:0] d; logic rl; logic l; } beat_t;
  typedef struct { int bank; int rows; int mode; int beats; int done; int err; } vec_t;

  logic [1023:0] mem [0:2][0:63];
  beat_t         exp_beats[$];
  logic [7:0]    exp_reads[$];
  int            n_cmp = 0, n_bad = 0;
  int            beats_seen = 0, done_cnt = 0, err_cnt = 0;
  int            ready_mode = 0;
  logic          mon_en = 1'b0;
  logic          stall_prev = 1'b0;
  logic [66:0]   prev_vec;
  logic [90:0]   all_out;

  assign all_out = {ren_a, ren_b, ren_c, raddr_a, raddr_b, raddr_c, out_valid, out_data,
                    out_row_last, out_last, busy, rd_done, rd_err};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // SRAM model: data appears the cycle after the read strobe
  initial begin
    forever begin
      @(posedge clk);
      if (ren_a) rdata_a <= mem[0][raddr_a];
      if (ren_b) rdata_b <= mem[1][raddr_b];
      if (ren_c) rdata_c <= mem[2][raddr_c];
    end
  end

  // Host ready pattern
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: reads, beats, stall stability and pulses against the model queues
  initial begin
    forever begin
      @(negedge clk);
      if (srstn && mon_en) begin
        if (stall_prev)
          chk("stall_hold", {61'd0, out_valid, out_row_last, out_last, out_data}, {61'd0, prev_vec});
        stall_prev = out_valid && !out_ready;
        prev_vec   = {out_valid, out_row_last, out_last, out_data};
        if (ren_a || ren_b || ren_c) begin
          if (exp_reads.size() == 0) begin
            chk("unexpected_read", 128'd1, 128'd0);
          end else begin
            logic [7:0]  r;
            logic [20:0] e;
            r = exp_reads.pop_front();
            e = 21'd0;
            if (r[7:6] == 2'd0) e = {3'b100, r[5:0], 6'd0, 6'd0};
            if (r[7:6] == 2'd1) e = {3'b010, 6'd0, r[5:0], 6'd0};
            if (r[7:6] == 2'd2) e = {3'b001, 6'd0, 6'd0, r[5:0]};
            chk("read_strobe", {107'd0, ren_a, ren_b, ren_c, raddr_a, raddr_b, raddr_c}, {107'd0, e});
          end
        end
        if (out_valid && out_ready) begin
          beats_seen++;
          if (exp_beats.size() == 0) begin
            chk("unexpected_beat", 128'd1, 128'd0);
          end else begin
            beat_t b;
            b = exp_beats.pop_front();
            chk("beat", {62'd0, out_row_last, out_last, out_data}, {62'd0, b.rl, b.l, b.d});
          end
        end
        if (rd_done) done_cnt++;
        if (rd_err)  err_cnt++;
      end
    end
  end

  // Model of one request: which rows are read and which beats come out
  task automatic start(input int bank, input int rows);
    int n;
    @(posedge clk);
    #1;
    rd_start = 1'b1;
    rd_bank  = 2'(bank);
    rd_rows  = 7'(rows);
    n = (rows > 64) ? 64 : rows;
    if (bank < 3) begin
      for (int r = 0; r < n; r++) begin
        exp_reads.push_back({2'(bank), 6'(r)});
        for (int b = 0; b < 16; b++) begin
          beat_t e;
          e.d  = mem[bank][r][b*64 +: 64];
          e.rl = (b == 15);
          e.l  = (b == 15) && (r == n - 1);
          exp_beats.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
    rd_start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    bit ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) chk("idle_timeout", 128'd0, 128'd1);
    @(negedge clk);
  endtask

  task automatic wait_beats(input int target);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (beats_seen >= target) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) chk("beat_timeout", 128'd0, 128'd1);
  endtask

  task automatic run_txn(input int bank, input int rows, input int mode,
                         input int ebeats, input int edone, input int eerr);
    int b0, d0, e0;
    ready_mode = mode;
    b0 = beats_seen; d0 = done_cnt; e0 = err_cnt;
    start(bank, rows);
    wait_idle(6000);
    chk($sformatf("beats_b%0d_r%0d", bank, rows), 128'(beats_seen - b0), 128'(ebeats));
    chk($sformatf("done_b%0d_r%0d", bank, rows), 128'(done_cnt - d0), 128'(edone));
    chk($sformatf("err_b%0d_r%0d", bank, rows), 128'(err_cnt - e0), 128'(eerr));
    chk("queues_empty", 128'(exp_beats.size() + exp_reads.size()), 128'd0);
  endtask

  vec_t vt [9];

  initial begin
    srstn = 1'b0; rd_start = 1'b0; rd_bank = 2'd0; rd_rows = 7'd0;
    rdata_a = '0; rdata_b = '0; rdata_c = '0;
    for (int k = 0; k < 3; k++)
      for (int r = 0; r < 64; r++)
        for (int w = 0; w < 32; w++)
          mem[k][r][w*32 +: 32] = $urandom;

    // Outputs stay zero under reset while inputs toggle
    ready_mode = 2;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      rd_start = 1'($urandom_range(0, 1));
      rd_bank  = 2'($urandom_range(0, 3));
      rd_rows  = 7'($urandom_range(0, 127));
      @(negedge clk);
      chk("reset_outputs", {37'd0, all_out}, 128'd0);
    end
    @(posedge clk);
    #1;
    rd_start = 1'b0;
    srstn = 1'b1;
    mon_en = 1'b1;

    // Exact cycle timing: bank b, two rows, always ready
    ready_mode = 0;
    repeat (2) @(posedge clk);
    start(1, 2);
    for (int k = 1; k <= 38; k++) begin
      logic ren, v, rl, l, d, bz;
      @(negedge clk);
      ren = (k == 1) || (k == 19);
      v   = (k >= 3 && k <= 18) || (k >= 21 && k <= 36);
      rl  = (k == 18) || (k == 36);
      l   = (k == 36);
      d   = (k == 37);
      bz  = (k <= 37);
      chk($sformatf("timing_k%0d", k),
          {116'd0, ren_b, raddr_b, out_valid, out_row_last, out_last, rd_done, busy},
          {116'd0, ren, (k == 19) ? 6'd1 : 6'd0, v, rl, l, d, bz});
    end
    chk("timing_queues", 128'(exp_beats.size() + exp_reads.size()), 128'd0);

    // Zero rows: done the cycle after the start, no strobes
    start(0, 0);
    @(negedge clk);
    chk("rows0_cycle1", {123'd0, rd_done, busy, ren_a, ren_b, ren_c}, {123'd0, 1'b1, 1'b1, 3'b000});
    wait_idle(10);

    // Illegal bank: error pulse, busy never rises
    start(3, 4);
    @(negedge clk);
    chk("bank3_cycle1", {126'd0, rd_err, busy}, {126'd0, 1'b1, 1'b0});
    wait_idle(10);

    vt[0] = '{0, 1, 1, 16, 1, 0};
    vt[1] = '{1, 2, 0, 32, 1, 0};
    vt[2] = '{2, 3, 2, 48, 1, 0};
    vt[3] = '{0, 0, 0, 0, 1, 0};
    vt[4] = '{3, 5, 0, 0, 0, 1};
    vt[5] = '{3, 0, 2, 0, 0, 1};
    vt[6] = '{1, 100, 0, 1024, 1, 0};
    vt[7] = '{2, 64, 2, 1024, 1, 0};
    vt[8] = '{0, 1, 1, 16, 1, 0};
    for (int i = 0; i < 9; i++)
      run_txn(vt[i].bank, vt[i].rows, vt[i].mode, vt[i].beats, vt[i].done, vt[i].err);

    for (int i = 0; i < 14; i++) begin
      int bk, rw;
      bk = $urandom_range(0, 3);
      rw = $urandom_range(0, 5);
      run_txn(bk, rw, 2, (bk < 3) ? 16 * rw : 0, (bk < 3) ? 1 : 0, (bk == 3) ? 1 : 0);
    end

    // A start request during SEND must be ignored
    begin
      int b0, d0;
      ready_mode = 2;
      b0 = beats_seen; d0 = done_cnt;
      start(2, 2);
      wait_beats(b0 + 4);
      @(posedge clk);
      #1;
      rd_start = 1'b1; rd_bank = 2'd0; rd_rows = 7'd5;
      @(posedge clk);
      #1;
      rd_start = 1'b0;
      wait_idle(2000);
      chk("ignore_start_beats", 128'(beats_seen - b0), 128'd32);
      chk("ignore_start_done", 128'(done_cnt - d0), 128'd1);
      chk("ignore_start_queues", 128'(exp_beats.size() + exp_reads.size()), 128'd0);
    end

    // Asynchronous reset during row 1 of 3, then a fresh request to bank c
    begin
      int b0;
      ready_mode = 0;
      b0 = beats_seen;
      start(0, 3);
      wait_beats(b0 + 21);
      @(negedge clk);
      chk("pre_reset_valid", {127'd0, out_valid}, 128'd1);
      mon_en = 1'b0;
      #2;
      srstn = 1'b0;
      #1;
      chk("async_reset_outputs", {37'd0, all_out}, 128'd0);
      exp_beats.delete();
      exp_reads.delete();
      stall_prev = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      srstn = 1'b1;
      mon_en = 1'b1;
      run_txn(2, 1, 2, 16, 1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
